// File: rtl/qv_stream_tx.sv
// Credit-gated streamer: latches a Q/K vector pair and sends it as interleaved
// words q0,k0,q1,k1,... over a valid/ready link, one credit consumed per word.
module qv_stream_tx #(
    parameter int N_FEAT  = 4,
    parameter int DW      = 8,
    parameter int CREDITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_vld,
    output logic                 load_rdy,
    input  logic [DW*N_FEAT-1:0] load_q,
    input  logic [DW*N_FEAT-1:0] load_k,
    output logic                 vld_mst_out,
    input  logic                 rdy_mst_in,
    output logic [DW-1:0]        data_mst_out,
    input  logic                 credit_ret,
    output logic                 busy,
    output logic                 done,
    output logic                 credit_ovf
);

    localparam int NW    = 2 * N_FEAT;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int CW    = $clog2(CREDITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);
    localparam logic [CW-1:0]    CRED_MAX = CW'(CREDITS);

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CW-1:0]        cred_q, cred_d;
    logic                 ovf_q, ovf_d;
    logic                 ovf_set;
    logic [DW*N_FEAT-1:0] q_q, k_q;
    logic signed [DW-1:0] word_d;
    logic                 accept;
    logic                 xfer;

    // Saturating credit update; MSB of the result flags a return beyond the maximum.
    function automatic logic [CW:0] credit_next(input logic [CW-1:0] cur,
                                                input logic          take,
                                                input logic          give);
        logic [CW:0] res;
        res = {1'b0, cur};
        case ({take, give})
            2'b10: res = {1'b0, cur - CW'(1)};
            2'b01: begin
                if (cur == CRED_MAX) res = {1'b1, cur};
                else                 res = {1'b0, cur + CW'(1)};
            end
            default: res = {1'b0, cur};
        endcase
        return res;
    endfunction

    assign accept = (state_q == S_IDLE) && load_vld;
    assign xfer   = vld_mst_out && rdy_mst_in;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (load_vld) begin
                    state_d = S_SEND;
                    idx_d   = '0;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (idx_q == IDX_LAST) state_d = S_DONE;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        {ovf_set, cred_d} = credit_next(cred_q, xfer, credit_ret);
        ovf_d             = ovf_q | ovf_set;
    end

    // Even index picks the query feature, odd index the key feature.
    always_comb begin
        word_d = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (idx_q == IDX_W'(2 * i))     word_d = q_q[i*DW +: DW];
            if (idx_q == IDX_W'(2 * i + 1)) word_d = k_q[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cred_q  <= CRED_MAX;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cred_q  <= cred_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload registers carry no reset; the output mux masks them outside SEND.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_q <= load_q;
            k_q <= load_k;
        end
    end

    assign vld_mst_out  = (state_q == S_SEND) && (cred_q != '0);
    assign data_mst_out = vld_mst_out ? word_d : '0;
    assign load_rdy     = (state_q == S_IDLE);
    assign busy         = (state_q == S_SEND) || (state_q == S_DONE);
    assign done         = (state_q == S_DONE);
    assign credit_ovf   = ovf_q;

endmodule

// File: tb/tb_qv_stream_tx.sv
// Directed bench for qv_stream_tx: scoreboard of expected stream words plus
// cycle-level checks of credit gating, backpressure, overflow and reset.
module tb_qv_stream_tx;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_vld = 1'b0;
    logic          load_rdy;
    logic [N*DW-1:0] load_q = '0;
    logic [N*DW-1:0] load_k = '0;
    logic          vld_mst_out;
    logic          rdy_mst_in = 1'b0;
    logic [DW-1:0] data_mst_out;
    logic          credit_ret = 1'b0;
    logic          busy;
    logic          done;
    logic          credit_ovf;

    int total = 0;
    int bad   = 0;
    int n_xfer = 0;
    int done_cnt = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] qv[N];
    logic [DW-1:0] kv[N];

    qv_stream_tx #(.N_FEAT(N), .DW(DW), .CREDITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_vld     (load_vld),
        .load_rdy     (load_rdy),
        .load_q       (load_q),
        .load_k       (load_k),
        .vld_mst_out  (vld_mst_out),
        .rdy_mst_in   (rdy_mst_in),
        .data_mst_out (data_mst_out),
        .credit_ret   (credit_ret),
        .busy         (busy),
        .done         (done),
        .credit_ovf   (credit_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are stable at the falling edge, so this predicts the next rising-edge transfer.
    always @(negedge clk) begin
        if (!rst && vld_mst_out && rdy_mst_in) begin
            n_xfer++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [DW-1:0] exp_w;
                exp_w = sb.pop_front();
                chk("word", {24'd0, data_mst_out}, {24'd0, exp_w});
            end
        end
        if (!rst && done === 1'b1) done_cnt++;
    end

    task automatic load_pair();
        chk("load_rdy_pre", {31'd0, load_rdy}, 32'd1);
        for (int i = 0; i < N; i++) begin
            load_q[i*DW +: DW] = qv[i];
            load_k[i*DW +: DW] = kv[i];
            sb.push_back(qv[i]);
            sb.push_back(kv[i]);
        end
        load_vld = 1'b1;
        tick();
        load_vld = 1'b0;
        load_q = {$urandom, $urandom};
        load_k = {$urandom, $urandom};
    endtask

    // Streams with rdy high, returning a credit one cycle after each transfer or
    // whenever the block is starved. Stops at done or after stop_after transfers.
    task automatic run_pair(input int stop_after);
        int base;
        int last;
        int cyc;
        bit fin;
        bit saw_done;
        base = n_xfer;
        last = n_xfer;
        cyc = 0;
        fin = 1'b0;
        saw_done = 1'b0;
        rdy_mst_in = 1'b1;
        while (!fin && cyc < 100) begin
            tick();
            cyc++;
            credit_ret = (n_xfer != last) || (busy && !done && !vld_mst_out);
            last = n_xfer;
            if (done) begin
                fin = 1'b1;
                saw_done = 1'b1;
            end
            if (stop_after > 0 && (n_xfer - base) >= stop_after) fin = 1'b1;
        end
        chk("run_timeout", {31'd0, fin}, 32'd1);
        if (saw_done) begin
            tick();
            credit_ret = 1'b0;
            rdy_mst_in = 1'b0;
            chk("load_rdy_after_done", {31'd0, load_rdy}, 32'd1);
            chk("done_single_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int base;
        int dbase;
        for (int i = 0; i < N; i++) begin
            qv[i] = DW'(i + 1);
            kv[i] = DW'(-(i + 1));
        end

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_load_rdy", {31'd0, load_rdy}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_vld", {31'd0, vld_mst_out}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data", {24'd0, data_mst_out}, 32'd0);
        chk("rst_ovf", {31'd0, credit_ovf}, 32'd0);

        // Full pair with prompt credit returns
        dbase = done_cnt;
        load_pair();
        chk("s1_busy", {31'd0, busy}, 32'd1);
        run_pair(0);
        chk("s1_done_cnt", done_cnt - dbase, 32'd1);
        chk("s1_sb_empty", sb.size(), 32'd0);
        chk("s1_ovf", {31'd0, credit_ovf}, 32'd0);

        // Credit exhaustion: two words, then stall until a credit comes back
        load_pair();
        base = n_xfer;
        rdy_mst_in = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("s2_xfers", n_xfer - base, 32'd2);
        chk("s2_vld_low", {31'd0, vld_mst_out}, 32'd0);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        chk("s2_vld_back", {31'd0, vld_mst_out}, 32'd1);
        chk("s2_data_02", {24'd0, data_mst_out}, 32'h02);
        run_pair(0);
        chk("s2_sb_empty", sb.size(), 32'd0);
        chk("s2_ovf", {31'd0, credit_ovf}, 32'd0);

        // Refill from 1 to 2 in IDLE must not overflow
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        chk("refill_ovf", {31'd0, credit_ovf}, 32'd0);

        // Backpressure: word held stable while rdy is low
        load_pair();
        chk("s3_vld", {31'd0, vld_mst_out}, 32'd1);
        base = n_xfer;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("s3_hold_vld", {31'd0, vld_mst_out}, 32'd1);
            chk("s3_hold_data", {24'd0, data_mst_out}, 32'h01);
        end
        rdy_mst_in = 1'b1;
        tick();
        rdy_mst_in = 1'b0;
        chk("s3_one_xfer", n_xfer - base, 32'd1);
        chk("s3_next_data", {24'd0, data_mst_out}, 32'hFF);

        // Transfer and credit return together with one credit: count stays 1
        rdy_mst_in = 1'b1;
        credit_ret = 1'b1;
        tick();
        rdy_mst_in = 1'b0;
        credit_ret = 1'b0;
        chk("s5_vld", {31'd0, vld_mst_out}, 32'd1);
        chk("s5_data", {24'd0, data_mst_out}, 32'h02);
        base = n_xfer;
        rdy_mst_in = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("s5_one_credit", n_xfer - base, 32'd1);
        chk("s5_vld_low", {31'd0, vld_mst_out}, 32'd0);
        run_pair(0);
        chk("s3_sb_empty", sb.size(), 32'd0);

        // Reset after the third transfer abandons the pair
        load_pair();
        base = n_xfer;
        run_pair(3);
        chk("s6_three", n_xfer - base, 32'd3);
        rdy_mst_in = 1'b0;
        credit_ret = 1'b0;
        rst = 1'b1;
        dbase = done_cnt;
        tick();
        rst = 1'b0;
        chk("s6_vld", {31'd0, vld_mst_out}, 32'd0);
        chk("s6_busy", {31'd0, busy}, 32'd0);
        chk("s6_load_rdy", {31'd0, load_rdy}, 32'd1);
        chk("s6_data", {24'd0, data_mst_out}, 32'd0);
        sb.delete();
        for (int c = 0; c < 4; c++) tick();
        chk("s6_no_done", done_cnt - dbase, 32'd0);

        // Overflow in IDLE with full credits: sticky flag, count saturates at 2
        chk("s4_ovf_pre", {31'd0, credit_ovf}, 32'd0);
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        chk("s4_ovf_set", {31'd0, credit_ovf}, 32'd1);
        for (int c = 0; c < 3; c++) tick();
        chk("s4_ovf_sticky", {31'd0, credit_ovf}, 32'd1);
        load_pair();
        base = n_xfer;
        rdy_mst_in = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        chk("s4_sat_xfers", n_xfer - base, 32'd2);
        chk("s4_vld_low", {31'd0, vld_mst_out}, 32'd0);
        run_pair(0);
        chk("s4_sb_empty", sb.size(), 32'd0);
        chk("s4_ovf_hold", {31'd0, credit_ovf}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s4_ovf_clr", {31'd0, credit_ovf}, 32'd0);
        chk("s4_load_rdy", {31'd0, load_rdy}, 32'd1);

        chk("total_done", done_cnt, 32'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
